// File: rtl/ahim_config_pkg.sv
// Shared definitions for the AHIM PIO command path: opcodes, request/response
// codes, the core controller's FSM-state codes and the command-master states.
package ahim_config_pkg;

  localparam logic [3:0] OP_NONE   = 4'h0;
  localparam logic [3:0] OP_INIT   = 4'h1;
  localparam logic [3:0] OP_UPLOAD = 4'h2;
  localparam logic [3:0] OP_ACK    = 4'h3;
  localparam logic [3:0] OP_RESET  = 4'hF;

  typedef enum logic [1:0] {
    REQ_INIT   = 2'd0,
    REQ_UPLOAD = 2'd1,
    REQ_ACK    = 2'd2,
    REQ_RESET  = 2'd3
  } pio_req_op_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERROR   = 2'd1,
    RSP_TIMEOUT = 2'd2
  } pio_rsp_status_e;

  // State codes reported by the core controller on fsm_state.
  typedef enum logic [3:0] {
    FSM_OFFLINE   = 4'h0,
    FSM_IDLE      = 4'h1,
    FSM_LOAD      = 4'h2,
    FSM_PROCESS   = 4'h3,
    FSM_WAIT_ACK  = 4'h4,
    FSM_ERROR_COM = 4'h5
  } ahim_fsm_state_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2,
    S_WAIT  = 2'd3
  } pio_master_state_e;

  function automatic logic [3:0] opcode_of(pio_req_op_e op);
    logic [3:0] code;
    case (op)
      REQ_INIT:   code = OP_INIT;
      REQ_UPLOAD: code = OP_UPLOAD;
      REQ_ACK:    code = OP_ACK;
      REQ_RESET:  code = OP_RESET;
      default:    code = OP_NONE;
    endcase
    return code;
  endfunction

  // True when the controller status shows the command has taken effect.
  function automatic logic cmd_complete(pio_req_op_e op, logic [3:0] fs,
                                        logic err, logic res_rdy);
    logic ok;
    case (op)
      REQ_INIT:   ok = (fs == FSM_IDLE);
      REQ_UPLOAD: ok = (fs != FSM_IDLE);
      REQ_ACK:    ok = (fs == FSM_IDLE) && !res_rdy;
      REQ_RESET:  ok = (fs == FSM_OFFLINE) && !err;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahim_pio_phase_timer.sv
// Loadable down-counter shared by the drive, gap and wait phases; done is high
// while enabled and the count has reached zero (the counter then holds at zero).
module ahim_pio_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = en && (count == '0);

endmodule

// File: rtl/ahim_pio_cmd_master.sv
// PIO command initiator: pulses {opcode, payload} on PIO_CMD, then confirms the
// command from controller status. Define AHIM_PIO_AUTO_ACK_EN to auto-ACK WAIT_ACK.
module ahim_pio_cmd_master #(
  parameter int HOLD_CYCLES    = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [27:0] req_payload,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [3:0]  rsp_fsm_state,
  output logic [7:0]  rsp_img_processed,
  output logic [7:0]  rsp_img_digits,
  output logic [7:0]  auto_ack_cnt,
  output logic [31:0] PIO_CMD,
  input  logic        busy,
  input  logic        result_ready,
  input  logic        error_flag,
  input  logic [3:0]  fsm_state,
  input  logic [7:0]  image_processed,
  input  logic [7:0]  images_with_digits,
  output logic [1:0]  dbg_state
);
  import ahim_config_pkg::*;

  localparam int WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int TW_A   = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
  localparam int TW     = (WAIT_W > TW_A) ? WAIT_W : TW_A;

  pio_master_state_e state;
  pio_req_op_e       op_q;
  logic              internal_q;
  logic              t_load, t_done, t_en;
  logic [TW-1:0]     t_val;
  logic              start, auto_go, err_hit, ok_hit, resolve;
  pio_rsp_status_e   status_d;
  logic              unused_busy;

  // busy only matters through the fsm_state the controller reports.
  assign unused_busy = busy;

`ifdef AHIM_PIO_AUTO_ACK_EN
  assign auto_go = !req_valid && (fsm_state == FSM_WAIT_ACK);
`else
  assign auto_go = 1'b0;
`endif

  assign start     = (state == S_IDLE) && (req_valid || auto_go);
  assign err_hit   = error_flag && (op_q != REQ_RESET);
  assign ok_hit    = cmd_complete(op_q, fsm_state, error_flag, result_ready);
  // The wait phase counts down from TIMEOUT_CYCLES, so reaching zero is the
  // same moment an up-counter from zero would equal TIMEOUT_CYCLES.
  assign resolve   = (state == S_WAIT) && (err_hit || ok_hit || t_done);
  assign status_d  = err_hit ? RSP_ERROR : (ok_hit ? RSP_OK : RSP_TIMEOUT);
  assign t_en      = (state != S_IDLE);
  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    case (state)
      S_IDLE:  if (start)  begin t_load = 1'b1; t_val = TW'(HOLD_CYCLES - 1); end
      S_DRIVE: if (t_done) begin t_load = 1'b1; t_val = TW'(GAP_CYCLES - 1);  end
      S_GAP:   if (t_done) begin t_load = 1'b1; t_val = TW'(TIMEOUT_CYCLES);  end
      default: ;
    endcase
  end

  ahim_pio_phase_timer #(.W(TW)) u_timer (
    .clk_in   (clk_in),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .done     (t_done)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state             <= S_IDLE;
      op_q              <= REQ_INIT;
      internal_q        <= 1'b0;
      PIO_CMD           <= {OP_NONE, 28'h0};
      rsp_valid         <= 1'b0;
      rsp_status        <= 2'd0;
      rsp_fsm_state     <= 4'd0;
      rsp_img_processed <= 8'd0;
      rsp_img_digits    <= 8'd0;
      auto_ack_cnt      <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q       <= req_valid ? pio_req_op_e'(req_op) : REQ_ACK;
            internal_q <= !req_valid;
            PIO_CMD    <= req_valid ? {opcode_of(pio_req_op_e'(req_op)), req_payload}
                                    : {OP_ACK, 28'h0};
            state      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (t_done) begin
            PIO_CMD <= {OP_NONE, 28'h0};
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (t_done) state <= S_WAIT;
        end
        S_WAIT: begin
          if (resolve) begin
            state <= S_IDLE;
            if (!internal_q) begin
              rsp_valid         <= 1'b1;
              rsp_status        <= status_d;
              rsp_fsm_state     <= fsm_state;
              rsp_img_processed <= image_processed;
              rsp_img_digits    <= images_with_digits;
            end
`ifdef AHIM_PIO_AUTO_ACK_EN
            else if (status_d == RSP_OK) begin
              auto_ack_cnt <= auto_ack_cnt + 8'd1;
            end
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahim_pio_cmd_master.sv
// Bench for ahim_pio_cmd_master: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the command timeline.
module tb_ahim_pio_cmd_master;
  import ahim_config_pkg::*;

  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int TO   = 20;

  logic        clk_in = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid;
  logic [1:0]  req_op, rsp_status, dbg_state;
  logic [27:0] req_payload;
  logic [3:0]  rsp_fsm_state, fsm_state;
  logic [7:0]  rsp_img_processed, rsp_img_digits, auto_ack_cnt;
  logic [7:0]  image_processed, images_with_digits;
  logic [31:0] PIO_CMD;
  logic        busy, result_ready, error_flag;

  always #5 clk_in = ~clk_in;

  ahim_pio_cmd_master #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_payload(req_payload), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_fsm_state(rsp_fsm_state),
    .rsp_img_processed(rsp_img_processed), .rsp_img_digits(rsp_img_digits),
    .auto_ack_cnt(auto_ack_cnt), .PIO_CMD(PIO_CMD), .busy(busy),
    .result_ready(result_ready), .error_flag(error_flag), .fsm_state(fsm_state),
    .image_processed(image_processed), .images_with_digits(images_with_digits),
    .dbg_state(dbg_state)
  );

  // Model: one outstanding command, described by its accept cycle m_a.
  bit          m_known, m_active, m_int, m_acc;
  int          m_a;
  logic [1:0]  m_op;
  logic [27:0] m_pl;
  logic        x_rsp_valid;
  logic [21:0] x_last;
  logic [7:0]  x_auto;
  logic [21:0] exp_q[$];
  int          cyc, n_vec, n_err;

  function automatic logic [3:0] opc(logic [1:0] op);
    case (op)
      2'd0:    return 4'h1;
      2'd1:    return 4'h2;
      2'd2:    return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic bit done_rule(logic [1:0] op);
    case (op)
      2'd0:    return fsm_state == FSM_IDLE;
      2'd1:    return fsm_state != FSM_IDLE;
      2'd2:    return (fsm_state == FSM_IDLE) && !result_ready;
      default: return (fsm_state == FSM_OFFLINE) && !error_flag;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Consumes the inputs present in cycle e, as the DUT samples them at edge e.
  task automatic model_edge(int e);
    int w;
    logic [1:0] st;
    bit hit;
    m_acc = 0;
    x_rsp_valid = 1'b0;
    if (rst) begin
      m_known = 1; m_active = 0; exp_q.delete(); x_last = '0; x_auto = '0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active = 1; m_int = 0; m_a = e; m_op = req_op; m_pl = req_payload; m_acc = 1;
      end
`ifdef AHIM_PIO_AUTO_ACK_EN
      else if (fsm_state == FSM_WAIT_ACK) begin
        m_active = 1; m_int = 1; m_a = e; m_op = 2'd2; m_pl = '0;
      end
`endif
    end else if (e >= m_a + 1 + HOLD + GAP) begin
      w = e - (m_a + 1 + HOLD + GAP);
      hit = 1; st = 2'd0;
      if (error_flag && m_op != 2'd3) st = 2'd1;
      else if (done_rule(m_op))       st = 2'd0;
      else if (w == TO)               st = 2'd2;
      else hit = 0;
      if (hit) begin
        m_active = 0;
        if (!m_int) begin
          exp_q.push_back({st, fsm_state, image_processed, images_with_digits});
          x_rsp_valid = 1'b1;
        end else if (st == 2'd0) begin
          x_auto = x_auto + 8'd1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_pio;
    if (m_known) begin
      exp_pio = '0;
      if (m_active && (cyc - m_a) >= 1 && (cyc - m_a) <= HOLD) exp_pio = {opc(m_op), m_pl};
      check("pio_cmd", PIO_CMD, exp_pio);
      check("req_ready", 32'(req_ready), 32'(!m_active));
      check("rsp_valid", 32'(rsp_valid), 32'(x_rsp_valid));
      if (x_rsp_valid && exp_q.size() > 0) x_last = exp_q.pop_front();
      check("rsp_status", 32'(rsp_status), 32'(x_last[21:20]));
      check("rsp_fsm_state", 32'(rsp_fsm_state), 32'(x_last[19:16]));
      check("rsp_img_processed", 32'(rsp_img_processed), 32'(x_last[15:8]));
      check("rsp_img_digits", 32'(rsp_img_digits), 32'(x_last[7:0]));
      check("auto_ack_cnt", 32'(auto_ack_cnt), 32'(x_auto));
    end
  endtask

  task automatic step();
    model_edge(cyc);
    @(posedge clk_in);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_active && n < 100) begin step(); n++; end
    if (m_active) begin
      n_vec++; n_err++;
      $display("FAIL idle_bound: command still open after %0d cycles", n);
    end
  endtask

  task automatic issue(logic [1:0] op, logic [27:0] pl, output int a);
    req_valid = 1'b1; req_op = op; req_payload = pl; a = cyc;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, rsp_seen, accepts, bursts, nz, zrun, min_gap, rsp_cnt, n30;
    bit prev_nz;
    cyc = 0; n_vec = 0; n_err = 0; m_known = 0; m_active = 0; x_auto = '0; x_last = '0;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_payload = '0; busy = 1'b0;
    result_ready = 1'b0; error_flag = 1'b0; fsm_state = FSM_OFFLINE;
    image_processed = 8'h11; images_with_digits = 8'h22;
    repeat (3) step();
    rst = 1'b0;
    check("reset_pio", PIO_CMD, 32'h0);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_auto_cnt", 32'(auto_ack_cnt), 32'd0);
    step();

    // INIT: controller reaches IDLE at cycle 6, response at cycle 10.
    issue(2'd0, 28'h0123456, a);
    rsp_seen = -1;
    for (int k = 1; k <= 12; k++) begin
      if (k <= HOLD) check("t1_pio_op", PIO_CMD, 32'h10123456);
      else if (k <= HOLD + GAP) check("t1_pio_gap", PIO_CMD, 32'h0);
      if (rsp_valid === 1'b1 && rsp_seen < 0) rsp_seen = k;
      if (k == 6) fsm_state = FSM_IDLE;
      step();
    end
    check("t1_rsp_cycle", 32'(rsp_seen), 32'd10);
    check("t1_status", 32'(rsp_status), 32'd0);
    check("t1_fsm_snap", 32'(rsp_fsm_state), 32'(FSM_IDLE));

    // Two back-to-back ACKs.
    wait_idle();
    fsm_state = FSM_IDLE; result_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'd2; req_payload = '0;
    accepts = 0; bursts = 0; nz = 0; zrun = 0; min_gap = 999; rsp_cnt = 0; prev_nz = 0;
    for (int k = 0; k < 30; k++) begin
      if (PIO_CMD === 32'h30000000) begin
        if (!prev_nz) begin
          bursts++;
          if (bursts > 1 && zrun < min_gap) min_gap = zrun;
        end
        prev_nz = 1; zrun = 0; nz++;
      end else begin
        prev_nz = 0; zrun++;
      end
      if (rsp_valid === 1'b1) rsp_cnt++;
      step();
      if (m_acc) accepts++;
      if (accepts == 2) req_valid = 1'b0;
    end
    check("t2_bursts", 32'(bursts), 32'd2);
    check("t2_opcode_cycles", 32'(nz), 32'd8);
    check("t2_gap_ge4", 32'(min_gap >= GAP), 32'd1);
    check("t2_rsp_count", 32'(rsp_cnt), 32'd2);
    check("t2_status", 32'(rsp_status), 32'd0);

    // UPLOAD with the controller stuck in IDLE: timeout.
    wait_idle();
    issue(2'd1, 28'h0ABCDEF, a);
    rsp_seen = -1;
    for (int k = 1; k <= 34; k++) begin
      if (rsp_valid === 1'b1 && rsp_seen < 0) rsp_seen = k;
      step();
    end
    check("t3_rsp_cycle", 32'(rsp_seen), 32'd30);
    check("t3_status", 32'(rsp_status), 32'd2);

    // UPLOAD hitting an error at cycle 9.
    wait_idle();
    image_processed = 8'h5A; images_with_digits = 8'hC3;
    issue(2'd1, 28'h1234567, a);
    rsp_seen = -1;
    for (int k = 1; k <= 14; k++) begin
      if (rsp_valid === 1'b1 && rsp_seen < 0) rsp_seen = k;
      if (k == 9) begin error_flag = 1'b1; fsm_state = FSM_ERROR_COM; end
      step();
    end
    check("t4_rsp_cycle", 32'(rsp_seen), 32'd10);
    check("t4_status", 32'(rsp_status), 32'd1);
    check("t4_fsm_snap", 32'(rsp_fsm_state), 32'(FSM_ERROR_COM));
    check("t4_img_snap", 32'(rsp_img_processed), 32'h5A);

    // RESET ignores error_flag; controller reaches OFFLINE at cycle 12.
    wait_idle();
    error_flag = 1'b1; fsm_state = FSM_ERROR_COM;
    issue(2'd3, 28'h0000001, a);
    check("t5_pio_reset_op", PIO_CMD, 32'hF0000001);
    rsp_seen = -1;
    for (int k = 1; k <= 16; k++) begin
      if (rsp_valid === 1'b1 && rsp_seen < 0) rsp_seen = k;
      if (k == 12) begin fsm_state = FSM_OFFLINE; error_flag = 1'b0; end
      step();
    end
    check("t5_rsp_cycle", 32'(rsp_seen), 32'd13);
    check("t5_status", 32'(rsp_status), 32'd0);

    // Reset during the drive phase aborts silently.
    wait_idle();
    issue(2'd0, 28'hABCDEF0, a);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_abort_pio", PIO_CMD, 32'h0);
    check("t5_abort_ready", 32'(req_ready), 32'd1);
    rsp_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (rsp_valid === 1'b1) rsp_cnt++;
      step();
    end
    check("t5_abort_no_rsp", 32'(rsp_cnt), 32'd0);

    // Controller waiting for ACK while idle.
    wait_idle();
    result_ready = 1'b0; fsm_state = FSM_WAIT_ACK;
    n30 = 0; rsp_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (PIO_CMD === 32'h30000000) n30++;
      if (rsp_valid === 1'b1) rsp_cnt++;
`ifdef AHIM_PIO_AUTO_ACK_EN
      if (k >= 1 && k <= 9) check("t6_ready_low", 32'(req_ready), 32'd0);
`else
      check("t6_ready_high", 32'(req_ready), 32'd1);
`endif
      if (k == 3) fsm_state = FSM_IDLE;
      step();
    end
`ifdef AHIM_PIO_AUTO_ACK_EN
    check("t6_ack_cycles", 32'(n30), 32'd4);
    check("t6_auto_cnt", 32'(auto_ack_cnt), 32'd1);
`else
    check("t6_ack_cycles", 32'(n30), 32'd0);
    check("t6_auto_cnt", 32'(auto_ack_cnt), 32'd0);
`endif
    check("t6_no_rsp", 32'(rsp_cnt), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) fsm_state = 4'($urandom_range(0, 5));
      error_flag = ($urandom_range(0, 15) == 0);
      result_ready = 1'($urandom_range(0, 1));
      busy = 1'($urandom_range(0, 1));
      image_processed = 8'($urandom);
      images_with_digits = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      if (!req_valid && $urandom_range(0, 3) == 0) begin
        req_valid = 1'b1;
        req_op = 2'($urandom_range(0, 3));
        req_payload = 28'($urandom);
      end
      step();
      if (m_acc) req_valid = 1'b0;
    end
    rst = 1'b0; req_valid = 1'b0;
    wait_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahim_pio_cmd_master.md
Name: ahim_pio_cmd_master

Overview:
- Initiator side of the HPS PIO command interface that the core controller decodes.
- Accepts high-level requests (INIT, UPLOAD, ACK, RESET) with a 28-bit payload.
- Drives the 32-bit PIO_CMD word as {opcode[31:28], payload[27:0]}, then returns it to the no-command opcode so a repeated command is seen as a new edge.
- Watches controller status (fsm_state, error_flag, result_ready) to confirm each command, and returns one response per request. Used as an on-fabric host or sequencer and as the bench driver.

Parameters:
- HOLD_CYCLES, 4: cycles the opcode and payload are held on PIO_CMD. Must be ≥1.
- GAP_CYCLES, 4: cycles PIO_CMD is held at all-zero after the hold. Must be ≥1.
- TIMEOUT_CYCLES, 65535: maximum cycles in S_WAIT before a TIMEOUT response.

Ports:
- clk_in  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in S_IDLE
- req_op  in  2  0=INIT, 1=UPLOAD, 2=ACK, 3=RESET
- req_payload  in  28  command payload
- rsp_valid  out  1  one-cycle response pulse
- rsp_status  out  2  0=OK, 1=ERROR, 2=TIMEOUT
- rsp_fsm_state  out  4  fsm_state snapshot
- rsp_img_processed  out  8  image_processed snapshot
- rsp_img_digits  out  8  images_with_digits snapshot
- auto_ack_cnt  out  8  count of automatic ACKs completed OK
- PIO_CMD  out  32  command word to the core controller
- busy  in  1  controller busy
- result_ready  in  1  controller result ready
- error_flag  in  1  controller error flag
- fsm_state  in  4  controller state code
- image_processed  in  8  controller counter
- images_with_digits  in  8  controller counter

Behaviour:
- Reset: state S_IDLE. PIO_CMD=0, rsp_valid=0, all rsp_* fields=0, auto_ack_cnt=0, counters=0.
- Reset mid-operation aborts the command: PIO_CMD=0 at the next edge and no response is emitted.
- States: S_IDLE → S_DRIVE → S_GAP → S_WAIT → S_IDLE.
- S_IDLE:
  - req_ready=1.
  - On req_valid: latch op and payload, register PIO_CMD={OPCODE(op), req_payload}, go to S_DRIVE.
- S_DRIVE: hold PIO_CMD for exactly HOLD_CYCLES cycles. Then PIO_CMD=0 and go to S_GAP.
- S_GAP: PIO_CMD=0 for exactly GAP_CYCLES cycles. Then go to S_WAIT with the wait counter cleared.
- S_WAIT: the following are evaluated every cycle, in priority order:
  1. error_flag=1 and op≠RESET → ERROR.
  2. Completion condition true → OK.
  3. Wait counter == TIMEOUT_CYCLES → TIMEOUT.
  4. Otherwise the counter increments. Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates.
- Completion conditions (state codes from the shared FSM-state enum):
  - INIT: fsm_state==IDLE.
  - UPLOAD: fsm_state≠IDLE.
  - ACK: fsm_state==IDLE and result_ready=0.
  - RESET: fsm_state==OFFLINE and error_flag=0.
- Response:
  - On the resolving cycle, snapshot fsm_state, image_processed and images_with_digits.
  - The next cycle: rsp_valid=1 with status, then return to S_IDLE. rsp_* fields hold until the next response.
- Latency:
  - Request accepted on edge 0 → opcode visible on cycles 1..HOLD.
  - Zeros on cycles HOLD+1..HOLD+GAP.
  - First evaluation at cycle 1+HOLD+GAP; earliest rsp_valid at cycle 2+HOLD+GAP (10 with defaults).
- busy is not a completion term. It is only reflected through the fsm_state snapshot.
- Back-to-back requests always have ≥GAP_CYCLES zero cycles between opcodes.

Optional Feature:
- Macro: AHIM_PIO_AUTO_ACK_EN.
- Defined:
  - In S_IDLE with req_valid=0 and fsm_state==WAIT_ACK, the block issues an internal ACK (payload 0) through the same DRIVE/GAP/WAIT sequence.
  - req_ready=0 while the internal ACK runs.
  - No rsp_valid is produced for an internal ACK.
  - auto_ack_cnt increments (wrapping) on each OK completion.
  - A pending req_valid has priority over the auto-ACK.
- Undefined: WAIT_ACK is ignored and auto_ack_cnt stays 0.

Decomposition:
- In ahim_config_pkg:
  - Opcode constants: OP_NONE=4'h0, OP_INIT=4'h1, OP_UPLOAD=4'h2, OP_ACK=4'h3, OP_RESET=4'hF.
  - A pio_req_op_e enum.
  - A pio_rsp_status_e enum.
  - Reuse of the existing FSM-state enum for IDLE, OFFLINE and WAIT_ACK.
- Sub-module ahim_pio_phase_timer: a loadable down-counter with a done pulse, shared by the S_DRIVE, S_GAP and S_WAIT phases.

Test Plan:
1. INIT, payload 0x0123456, defaults; model moves fsm_state OFFLINE→IDLE at cycle 6 → PIO_CMD=0x10123456 on cycles 1-4, 0 on cycles 5-8; rsp_valid at cycle 10, status OK.
2. Two back-to-back ACK requests, model holding fsm_state=IDLE and result_ready=0 → two 0x30000000 bursts, each separated by ≥4 zero cycles; two OK responses.
3. UPLOAD with TIMEOUT_CYCLES=20 and fsm_state stuck at IDLE → rsp_valid at cycle 30, status TIMEOUT.
4. UPLOAD; model raises error_flag and sets fsm_state=ERROR_COM at cycle 9 → status ERROR, rsp_fsm_state=ERROR_COM code.
5. RESET with error_flag=1; model clears to OFFLINE at cycle 12 → status OK. Separately, rst asserted during S_DRIVE → PIO_CMD=0 next cycle, no rsp_valid, req_ready=1.
6. Auto-ACK with macro defined: fsm_state=WAIT_ACK while idle → 0x30000000 driven, req_ready=0 during the sequence, auto_ack_cnt 0→1, no rsp_valid. Macro undefined → PIO_CMD stays 0.
